// File: rtl/mul_ctrl.sv
// mul_ctrl: HI/LO owner that sequences a multicycle combinational multiplier
// and folds in the unsigned correction for MULTU.
module mul_ctrl #(
   parameter int MUL_CYCLES = 2,
   parameter int CNT_W      = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        op_signed,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic [31:0] wdata,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   input  logic [63:0] mul_z,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);
   typedef enum logic {IDLE, CALC} state_t;
   state_t state, state_n;
   logic [CNT_W-1:0] cnt;
   logic sgn, accept, finish, wr_hi, wr_lo;
   logic [63:0] prod;
   always_ff @(posedge clk)
      state <= !reset ? IDLE : state_n;
   always_comb
      state_n = (state == IDLE) ? (start ? CALC : IDLE) : (cnt == '0 ? IDLE : CALC);
   // Signed product plus the two-complement fix-ups turns it into the unsigned product
   always_comb begin
      accept = state == IDLE && start;
      finish = state == CALC && cnt == '0;
      wr_hi  = state == IDLE && !start && mthi;
      wr_lo  = state == IDLE && !start && mtlo;
      prod   = mul_z + (sgn ? 64'd0 : {(mul_b[31] ? mul_a : 32'd0), 32'd0}
                                    + {(mul_a[31] ? mul_b : 32'd0), 32'd0});
   end
   always_ff @(posedge clk)
      if (!reset) begin
         mul_a <= '0;
         mul_b <= '0;
         sgn   <= 1'b0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         done <= finish;
         if (accept) begin
            mul_a <= a;
            mul_b <= b;
            sgn   <= op_signed;
            cnt   <= CNT_W'(MUL_CYCLES - 1);
            busy  <= 1'b1;
         end else if (finish)
            busy <= 1'b0;
         else if (state == CALC)
            cnt <= cnt - CNT_W'(1);
         if (finish)
            {hi, lo} <= prod;
         else begin
            if (wr_hi) hi <= wdata;
            if (wr_lo) lo <= wdata;
         end
      end
endmodule

// File: tb/tb_mul_ctrl.sv
// tb_mul_ctrl: directed vectors against mul_ctrl built with MUL_CYCLES = 2, 4 and 1.
module tb_mul_ctrl;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        op_signed, mthi, mtlo;
   logic [31:0] a, b, wdata;
   logic [2:0]  start_v, reset_v, busy_v, done_v;
   logic [31:0] ma_v [3];
   logic [31:0] mb_v [3];
   logic [63:0] z_v  [3];
   logic [31:0] hi_v [3];
   logic [31:0] lo_v [3];
   int mcs [3] = '{2, 4, 1};
   int pass_cnt = 0, total_cnt = 0;

   for (genvar g = 0; g < 3; g++)
      assign z_v[g] = $signed({{32{ma_v[g][31]}}, ma_v[g]}) * $signed({{32{mb_v[g][31]}}, mb_v[g]});

   mul_ctrl #(.MUL_CYCLES(2), .CNT_W(4)) u_mc2 (
      .clk(clk), .reset(reset_v[0]), .start(start_v[0]), .op_signed(op_signed), .a(a), .b(b),
      .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .mul_a(ma_v[0]), .mul_b(mb_v[0]), .mul_z(z_v[0]),
      .busy(busy_v[0]), .done(done_v[0]), .hi(hi_v[0]), .lo(lo_v[0]));
   mul_ctrl #(.MUL_CYCLES(4), .CNT_W(4)) u_mc4 (
      .clk(clk), .reset(reset_v[1]), .start(start_v[1]), .op_signed(op_signed), .a(a), .b(b),
      .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .mul_a(ma_v[1]), .mul_b(mb_v[1]), .mul_z(z_v[1]),
      .busy(busy_v[1]), .done(done_v[1]), .hi(hi_v[1]), .lo(lo_v[1]));
   mul_ctrl #(.MUL_CYCLES(1), .CNT_W(4)) u_mc1 (
      .clk(clk), .reset(reset_v[2]), .start(start_v[2]), .op_signed(op_signed), .a(a), .b(b),
      .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .mul_a(ma_v[2]), .mul_b(mb_v[2]), .mul_z(z_v[2]),
      .busy(busy_v[2]), .done(done_v[2]), .hi(hi_v[2]), .lo(lo_v[2]));

   typedef struct {
      logic        s;
      logic [31:0] x, y, eh, el;
      string       nm;
   } vec_t;
   vec_t vecs [8];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Issues one op on instance i and checks busy length, the done pulse and HI/LO.
   task automatic run_op(input int i, input logic s, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eh, input logic [31:0] el, input logic wm, input string nm);
      @(negedge clk);
      start_v[i] = 1'b1; op_signed = s; a = x; b = y; mtlo = wm; wdata = 32'hAAAA_5555;
      @(negedge clk);
      start_v[i] = 1'b0; mtlo = 1'b0;
      for (int k = 0; k < mcs[i]; k++) begin
         chk({nm, " busy"}, busy_v[i], 1);
         chk({nm, " done_early"}, done_v[i], 0);
         @(negedge clk);
      end
      chk({nm, " busy_end"}, busy_v[i], 0);
      chk({nm, " done"}, done_v[i], 1);
      chk({nm, " hi"}, hi_v[i], eh);
      chk({nm, " lo"}, lo_v[i], el);
      @(negedge clk);
      chk({nm, " done_clear"}, done_v[i], 0);
   endtask

   initial begin
      vecs[0] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mult_m1x2"};
      vecs[1] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max"};
      vecs[2] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, "mult_m1m1"};
      vecs[3] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_min"};
      vecs[4] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "multu_min"};
      vecs[5] = '{1'b0, 32'h8000_0000, 32'h0000_0003, 32'h0000_0001, 32'h8000_0000, "multu_msbx3"};
      vecs[6] = '{1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, "mult_max"};
      vecs[7] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, "multu_m1x2"};

      start_v = '0; reset_v = '0; op_signed = 1'b0; a = '0; b = '0;
      mthi = 1'b0; mtlo = 1'b0; wdata = '0;
      repeat (2) @(negedge clk);
      reset_v = '1;
      chk("rst hi", hi_v[0], 0);
      chk("rst lo", lo_v[0], 0);
      chk("rst busy", busy_v[0], 0);
      chk("rst done", done_v[0], 0);
      chk("rst mul_a", ma_v[0], 0);
      chk("rst mul_b", mb_v[0], 0);

      foreach (vecs[v]) run_op(0, vecs[v].s, vecs[v].x, vecs[v].y, vecs[v].eh, vecs[v].el, 1'b0, vecs[v].nm);

      // start held high through an in-flight op, then accepted in the done cycle
      @(negedge clk);
      start_v[0] = 1'b1; op_signed = 1'b1; a = 32'd3; b = 32'd4;
      @(negedge clk);
      a = 32'd5; b = 32'd7;
      chk("ign busy0", busy_v[0], 1);
      @(negedge clk);
      chk("ign busy1", busy_v[0], 1);
      chk("ign mul_a", ma_v[0], 3);
      chk("ign mul_b", mb_v[0], 4);
      @(negedge clk);
      chk("ign done", done_v[0], 1);
      chk("ign busy_end", busy_v[0], 0);
      chk("ign lo", lo_v[0], 12);
      chk("ign hi", hi_v[0], 0);
      @(negedge clk);
      start_v[0] = 1'b0;
      chk("b2b busy0", busy_v[0], 1);
      chk("b2b done_clear", done_v[0], 0);
      chk("b2b mul_a", ma_v[0], 5);
      @(negedge clk);
      chk("b2b busy1", busy_v[0], 1);
      @(negedge clk);
      chk("b2b done", done_v[0], 1);
      chk("b2b lo", lo_v[0], 35);
      chk("hold mul_b", mb_v[0], 7);

      @(negedge clk);
      mthi = 1'b1; wdata = 32'h1234_5678;
      @(negedge clk);
      mthi = 1'b0;
      chk("mthi hi", hi_v[0], 32'h1234_5678);
      chk("mthi lo", lo_v[0], 35);

      @(negedge clk);
      start_v[0] = 1'b1; op_signed = 1'b0; a = 32'd3; b = 32'd4;
      @(negedge clk);
      start_v[0] = 1'b0; mtlo = 1'b1; wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("mtlo_busy lo", lo_v[0], 35);
      @(negedge clk);
      mtlo = 1'b0;
      chk("mtlo_busy done", done_v[0], 1);
      chk("mtlo_busy lo_final", lo_v[0], 12);

      run_op(0, 1'b0, 32'd6, 32'd7, 32'd0, 32'd42, 1'b1, "start_mtlo");

      // abort a MUL_CYCLES=4 op in its second CALC cycle
      @(negedge clk);
      start_v[1] = 1'b1; op_signed = 1'b1; a = 32'd3; b = 32'd4;
      @(negedge clk);
      start_v[1] = 1'b0;
      chk("abort busy0", busy_v[1], 1);
      @(negedge clk);
      reset_v[1] = 1'b0;
      chk("abort hi_pre", hi_v[1], 32'h1234_5678);
      @(negedge clk);
      reset_v[1] = 1'b1;
      chk("abort hi", hi_v[1], 0);
      chk("abort lo", lo_v[1], 0);
      chk("abort busy", busy_v[1], 0);
      chk("abort done", done_v[1], 0);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("abort no_done", done_v[1], 0);
      end
      run_op(1, 1'b1, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, "mc4_after_rst");
      run_op(2, 1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, "mc1_basic");

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/mul_ctrl.md
Name: mul_ctrl

Overview:
Sequencing controller for the CPU's combinational 32x32 signed carry-save multiplier. It owns the HI/LO register pair and accepts MULT/MULTU requests from the execute stage. It holds stable operands on the multiplier for a fixed multicycle budget, applies unsigned correction for MULTU, and writes HI/LO. It also serves MTHI/MTLO writes and raises busy so the pipeline stalls MFHI/MFLO and further mult ops.

Parameters:
MUL_CYCLES, 2, cycles the operands are held before mul_z is sampled (multicycle path budget); legal range 1..15
CNT_W, 4, width of the internal cycle counter; must hold MUL_CYCLES-1

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-low reset
start  in  1  request a multiply, sampled only in IDLE
op_signed  in  1  1 = MULT (signed), 0 = MULTU (unsigned), sampled with start
a  in  32  rs operand, sampled with start
b  in  32  rt operand, sampled with start
mthi  in  1  write wdata to HI
mtlo  in  1  write wdata to LO
wdata  in  32  data for mthi/mtlo
mul_a  out  32  registered operand to multiplier input a
mul_b  out  32  registered operand to multiplier input b
mul_z  in  64  signed product returned by multiplier
busy  out  1  operation in flight; pipeline stalls HI/LO users
done  out  1  one-cycle pulse: HI/LO updated on this edge
hi  out  32  HI register
lo  out  32  LO register

Behaviour:
- Reset (reset==0 at an edge): state=IDLE; busy=0, done=0, hi=0, lo=0, mul_a=0, mul_b=0, counter=0, signed flag=0. Reset in the middle of CALC aborts the operation. No done pulse is produced and HI/LO are cleared.
- States: IDLE and CALC.
- IDLE, start=1 at edge E0:
  - mul_a<=a, mul_b<=b, sgn<=op_signed, cnt<=MUL_CYCLES-1.
  - state<=CALC, busy<=1.
- CALC:
  - mul_a/mul_b are held constant.
  - If cnt!=0: cnt<=cnt-1.
  - If cnt==0: hi/lo<=corrected product, done<=1, busy<=0, state<=IDLE.
- Latency: HI/LO update at edge E0+MUL_CYCLES. busy is high for exactly MUL_CYCLES cycles. done is high for the single cycle following the update.
- done is cleared on every edge where it is not being set.
- Product correction, all arithmetic mod 2^64:
  - sgn=1: prod=mul_z.
  - sgn=0: prod = mul_z + ({mul_b[31]?mul_a:0,32'b0}) + ({mul_a[31]?mul_b:0,32'b0}).
  - hi=prod[63:32], lo=prod[31:0].
- start while busy: ignored. Operands are not re-sampled and there is no queueing.
- start in the cycle done=1 (state is already IDLE): accepted, back-to-back with no bubble.
- mthi/mtlo:
  - Applied at the edge only in IDLE with start=0.
  - Both asserted: both written with wdata.
  - While busy: ignored.
  - start together with mthi/mtlo in IDLE: start wins and the writes are discarded.
- hi/lo are driven directly from registers. During CALC they hold their previous values.
- mul_a/mul_b keep their last operands after completion. They change only on an accepted start or on reset.

Test Plan:
(The bench drives mul_z with a combinational signed-multiply model of mul_a*mul_b.)
- MUL_CYCLES=2, MULT a=0xFFFFFFFF, b=0x00000002 -> busy high 2 cycles; at E0+2 hi=0xFFFFFFFF, lo=0xFFFFFFFE; done pulses exactly 1 cycle.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. MULT with the same operands -> hi=0x00000000, lo=0x00000001.
- MULT a=b=0x80000000 -> hi=0x40000000, lo=0. MULTU with the same operands -> hi=0x40000000, lo=0. MULTU a=0x80000000, b=3 -> hi=0x00000001, lo=0x80000000.
- start with a=5, b=7 while busy during an in-flight 3x4 op -> result hi=0, lo=12 and busy length unchanged. Then start 5x7 in the done cycle -> accepted, lo=35 after MUL_CYCLES more cycles with no idle gap.
- mthi wdata=0x12345678 in IDLE -> hi=0x12345678 next edge. mtlo during busy -> lo unaffected. start together with mtlo -> mtlo dropped, lo=product.
- MUL_CYCLES=4, drive reset low at the second CALC cycle -> next edge hi=lo=0, busy=0, no done pulse. Then a start after reset is released completes normally. Repeat the basic case with MUL_CYCLES=1 -> update at E0+1.
